// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter in front of a byte-level SPI shift engine.
// Grants whole frames round-robin and owns chip-select timing: setup before the first byte,
// hold after the last engine completion and a minimum gap before the next grant. Bytes are
// passed to the engine one at a time and each received byte is returned to the frame owner.
//
// Ports
//   clk_i, rst_ni        system clock, asynchronous active-low reset
//   req_valid_i[1:0]     per-requester byte valid
//   req_data_i[15:0]     [8i+7:8i] byte from requester i
//   req_last_i[1:0]      byte closes the frame
//   req_ready_o[1:0]     byte accepted when valid & ready (combinational)
//   rsp_valid_o[1:0]     one-cycle pulse, rsp_data_o belongs to requester i
//   rsp_data_o[7:0]      received byte
//   grant_o[1:0]         one-hot frame owner, 0 when idle
//   abort_o[1:0]         one-cycle pulse, owner's frame aborted by inactivity timeout
//   eng_start_o          one-cycle pulse, engine shifts eng_tx_data_o
//   eng_tx_data_o[7:0]   byte for the engine
//   eng_busy_i           engine is shifting
//   eng_done_i           one-cycle pulse, eng_rx_data_i valid
//   eng_rx_data_i[7:0]   byte received by the engine
//   cs_o                 active-low chip select
module spi_bus_arbiter #(
  parameter int unsigned CS_SETUP_CYCLES = 2,
  parameter int unsigned CS_HOLD_CYCLES  = 2,
  parameter int unsigned CS_GAP_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req_data_i,
  input  logic [1:0]  req_last_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic [1:0]  grant_o,
  output logic [1:0]  abort_o,
  output logic        eng_start_o,
  output logic [7:0]  eng_tx_data_o,
  input  logic        eng_busy_i,
  input  logic        eng_done_i,
  input  logic [7:0]  eng_rx_data_i,
  output logic        cs_o
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxCycles = max2(max2(CS_SETUP_CYCLES, CS_HOLD_CYCLES),
                                           max2(CS_GAP_CYCLES, TIMEOUT_CYCLES));
  localparam int unsigned CntW      = (MaxCycles < 1) ? 1 : $clog2(MaxCycles + 1);

  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CS_GAP_CYCLES - 1);
  localparam logic [CntW-1:0] TmoLast   =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StArmed,
    StWait,
    StHold,
    StGap
  } state_e;

  state_e          state_q;
  logic [1:0]      grant_q;
  logic            rr_q;          // requester favoured on the next simultaneous request
  logic            last_q;        // in-flight byte closes the frame
  logic [CntW-1:0] cnt_q;         // shared by setup/hold/gap timing and the ARMED timeout
  logic            cs_q;
  logic [1:0]      rsp_valid_q;
  logic [7:0]      rsp_data_q;
  logic [1:0]      abort_q;
  logic            eng_start_q;
  logic [7:0]      eng_tx_data_q;

  logic            owner;
  logic            accept;
  logic [7:0]      owner_byte;
  logic            owner_last;
  logic [CntW-1:0] cnt_inc;

  always_comb begin
    owner       = grant_q[1];
    req_ready_o = ((state_q == StArmed) && !eng_busy_i) ? grant_q : 2'b00;
    accept      = |(req_valid_i & req_ready_o);
    owner_byte  = owner ? req_data_i[15:8] : req_data_i[7:0];
    owner_last  = req_last_i[owner];
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      grant_q       <= 2'b00;
      rr_q          <= 1'b0;
      last_q        <= 1'b0;
      cnt_q         <= '0;
      cs_q          <= 1'b1;
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= 8'h00;
      abort_q       <= 2'b00;
      eng_start_q   <= 1'b0;
      eng_tx_data_q <= 8'h00;
    end else begin
      rsp_valid_q <= 2'b00;
      abort_q     <= 2'b00;
      eng_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // The requester's byte stays pending; it is accepted later in ARMED.
          if (|req_valid_i) begin
            if (&req_valid_i) begin
              grant_q <= rr_q ? 2'b10 : 2'b01;
              rr_q    <= ~rr_q;
            end else begin
              grant_q <= req_valid_i;
            end
            cs_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == SetupLast) begin
            cnt_q   <= '0;
            state_q <= StArmed;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StArmed: begin
          if (accept) begin
            eng_start_q   <= 1'b1;
            eng_tx_data_q <= owner_byte;
            last_q        <= owner_last;
            cnt_q         <= '0;
            state_q       <= StWait;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TmoLast)) begin
            abort_q <= grant_q;
            cnt_q   <= '0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWait: begin
          if (eng_done_i) begin
            rsp_valid_q <= grant_q;
            rsp_data_q  <= eng_rx_data_i;
            cnt_q       <= '0;
            state_q     <= last_q ? StHold : StArmed;
          end
        end
        StHold: begin
          if (cnt_q == HoldLast) begin
            cs_q    <= 1'b1;
            grant_q <= 2'b00;
            cnt_q   <= '0;
            state_q <= StGap;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign grant_o       = grant_q;
  assign abort_o       = abort_q;
  assign eng_start_o   = eng_start_q;
  assign eng_tx_data_o = eng_tx_data_q;
  assign cs_o          = cs_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
module tb_spi_bus_arbiter;
  localparam int unsigned Setup = 2;
  localparam int unsigned Hold  = 2;
  localparam int unsigned Gap   = 2;
  localparam int unsigned Tmo   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Requester drivers
  logic       v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  // Engine model
  logic       busy_m = 1'b0, busy_force = 1'b0, done_m = 1'b0;
  logic [7:0] rx_m = 8'h00;
  int         eng_lat = 3;
  int         done_count = 0;

  logic [1:0]  req_valid, req_last, req_ready, rsp_valid, grant, abort;
  logic [15:0] req_data;
  logic [7:0]  rsp_data, eng_tx_data;
  logic        eng_start, eng_busy, cs;

  assign req_valid = {v1, v0};
  assign req_last  = {l1, l0};
  assign req_data  = {d1, d0};
  assign eng_busy  = busy_m | busy_force;

  spi_bus_arbiter #(
    .CS_SETUP_CYCLES(Setup),
    .CS_HOLD_CYCLES (Hold),
    .CS_GAP_CYCLES  (Gap),
    .TIMEOUT_CYCLES (Tmo)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_data_o   (rsp_data),
    .grant_o      (grant),
    .abort_o      (abort),
    .eng_start_o  (eng_start),
    .eng_tx_data_o(eng_tx_data),
    .eng_busy_i   (eng_busy),
    .eng_done_i   (done_m),
    .eng_rx_data_i(rx_m),
    .cs_o         (cs)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: filled when a byte is accepted, drained when the DUT produces output.
  logic [7:0] tx_q[$];
  logic [9:0] rsp_q[$];   // {one-hot owner, expected received byte}

  // Engine echoes the inverted byte after eng_lat busy cycles.
  initial begin
    logic [7:0] tx;
    forever begin
      @(negedge clk);
      if (eng_start) begin
        tx     = eng_tx_data;
        busy_m = 1'b1;
        repeat (eng_lat) @(negedge clk);
        busy_m = 1'b0;
        done_m = 1'b1;
        rx_m   = ~tx;
        done_count++;
        @(negedge clk);
        done_m = 1'b0;
      end
    end
  end

  // Monitor marks, sampled 1 ns after each falling edge.
  int         cyc = 0;
  int         fall_cyc_q[$], rise_cyc_q[$];
  logic [1:0] fall_grant_q[$];
  int         first_start_cyc = -1, done_cyc = -1, rsp_cyc = -1, abort_cyc = -1;
  int         rsp_count = 0, start_count = 0, overlap_cnt = 0;
  logic [1:0] abort_seen = 2'b00;
  logic       cs_prev = 1'b1;
  logic       want_first = 1'b0;

  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst_n) begin
        check("ready_non_owner", {30'b0, req_ready & ~grant}, 32'h0);
        if (v1 && grant == 2'b01) overlap_cnt++;
        if (cs_prev && !cs) begin
          fall_cyc_q.push_back(cyc);
          fall_grant_q.push_back(grant);
          want_first = 1'b1;
        end
        if (!cs_prev && cs) rise_cyc_q.push_back(cyc);
        if (eng_start) begin
          start_count++;
          if (want_first) first_start_cyc = cyc;
          want_first = 1'b0;
          if (tx_q.size() == 0) check("eng_start_unexpected", {31'b0, eng_start}, 32'h0);
          else check("eng_tx_data", {24'b0, eng_tx_data}, {24'b0, tx_q.pop_front()});
        end
        if (done_m) done_cyc = cyc;
        if (rsp_valid != 2'b00) begin
          rsp_count++;
          rsp_cyc = cyc;
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", {30'b0, rsp_valid}, 32'h0);
          end else begin
            e = rsp_q.pop_front();
            check("rsp_owner", {30'b0, rsp_valid}, {30'b0, e[9:8]});
            check("rsp_data", {24'b0, rsp_data}, {24'b0, e[7:0]});
          end
        end
        if (abort != 2'b00) begin
          abort_cyc  = cyc;
          abort_seen = abort;
        end
      end
      cs_prev = cs;
    end
  end

  task automatic clear_marks();
    fall_cyc_q.delete();
    rise_cyc_q.delete();
    fall_grant_q.delete();
    first_start_cyc = -1;
    abort_seen      = 2'b00;
    overlap_cnt     = 0;
  endtask

  // Offer one byte and hold it until accepted; expectations are queued at the accepting edge.
  task automatic send_byte(input int id, input logic [7:0] b, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    if (id == 0) begin v0 = 1'b1; d0 = b; l0 = last; end
    else         begin v1 = 1'b1; d1 = b; l1 = last; end
    #1;
    while (!req_ready[id] && t <= 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!req_ready[id]) begin
      check("accept_timeout", {31'b0, req_ready[id]}, 32'h1);
    end else begin
      tx_q.push_back(b);
      rsp_q.push_back({(id == 0) ? 2'b01 : 2'b10, ~b});
    end
    @(posedge clk);
    #1;
    if (id == 0) v0 = 1'b0;
    else         v1 = 1'b0;
  endtask

  // Wait for the frame to close, then let the gap expire so the arbiter is back in IDLE.
  task automatic wait_quiet();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((grant != 2'b00 || !cs || eng_busy) && t < 400);
    check("quiet", {29'b0, grant, cs}, 32'h1);
    repeat (Gap + 2) @(negedge clk);
  endtask

  // Two frames arbitrated back to back: owner order and cs-high time between them.
  task automatic two_frames(input logic [1:0] g_first, input logic [1:0] g_second);
    clear_marks();
    fork
      begin send_byte(0, 8'h11, 1'b0); send_byte(0, 8'h22, 1'b1); end
      begin send_byte(1, 8'h33, 1'b0); send_byte(1, 8'h44, 1'b1); end
    join
    wait_quiet();
    check("rr_frames", fall_grant_q.size(), 2);
    if (fall_grant_q.size() >= 2 && rise_cyc_q.size() >= 1) begin
      check("rr_first", {30'b0, fall_grant_q[0]}, {30'b0, g_first});
      check("rr_second", {30'b0, fall_grant_q[1]}, {30'b0, g_second});
      // GAP cycles plus the IDLE arbitration cycle
      check("rr_gap", fall_cyc_q[1] - rise_cyc_q[0], Gap + 1);
    end
  endtask

  int rc, dc, sc, t;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs", {31'b0, cs}, 32'h1);
    check("rst_grant", {30'b0, grant}, 32'h0);
    check("rst_ready", {30'b0, req_ready}, 32'h0);
    check("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("rst_eng_start", {31'b0, eng_start}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single three-byte frame from requester 0
    clear_marks();
    rc = rsp_count;
    send_byte(0, 8'hA5, 1'b0);
    send_byte(0, 8'h3C, 1'b0);
    send_byte(0, 8'hFF, 1'b1);
    wait_quiet();
    check("t1_rsp_count", rsp_count - rc, 3);
    check("t1_frames", fall_grant_q.size(), 1);
    if (fall_grant_q.size() >= 1 && rise_cyc_q.size() >= 1) begin
      check("t1_grant", {30'b0, fall_grant_q[0]}, 32'h1);
      // SETUP cycles, then the ARMED accept cycle, then the registered eng_start
      check("t1_setup", first_start_cyc - fall_cyc_q[0], Setup + 1);
      // cs stays low for Hold cycles after the cycle in which eng_done is seen
      check("t1_hold", rise_cyc_q[0] - done_cyc, Hold + 1);
    end

    // 2: simultaneous requests, round-robin order flips on the repeat
    two_frames(2'b01, 2'b10);
    two_frames(2'b10, 2'b01);

    // 3: requester 1 arrives mid-frame and waits for the gap
    clear_marks();
    fork
      begin send_byte(0, 8'h01, 1'b0); send_byte(0, 8'h02, 1'b0); send_byte(0, 8'h03, 1'b1); end
      begin repeat (6) @(negedge clk); send_byte(1, 8'h9A, 1'b1); end
    join
    wait_quiet();
    check("t3_overlap_seen", {31'b0, overlap_cnt > 0}, 32'h1);
    check("t3_frames", fall_grant_q.size(), 2);
    if (fall_grant_q.size() >= 2 && rise_cyc_q.size() >= 1) begin
      check("t3_first", {30'b0, fall_grant_q[0]}, 32'h1);
      check("t3_second", {30'b0, fall_grant_q[1]}, 32'h2);
      check("t3_gap", fall_cyc_q[1] - rise_cyc_q[0], Gap + 1);
    end

    // 4: owner stalls after one byte; timeout aborts the frame
    clear_marks();
    rc = rsp_count;
    send_byte(0, 8'h5E, 1'b0);
    t = 0;
    while (abort_seen == 2'b00 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    wait_quiet();
    check("t4_abort", {30'b0, abort_seen}, 32'h1);
    check("t4_abort_time", abort_cyc - rsp_cyc, Tmo);
    check("t4_rsp_count", rsp_count - rc, 1);
    if (rise_cyc_q.size() >= 1) check("t4_hold", rise_cyc_q[0] - abort_cyc, Hold);

    // 5: engine busy while ARMED blocks the accept
    clear_marks();
    @(negedge clk);
    busy_force = 1'b1;
    v0 = 1'b1; d0 = 8'h77; l0 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (grant != 2'b01 && t < 50);
    check("t5_grant", {30'b0, grant}, 32'h1);
    // two SETUP cycles then four ARMED cycles, under the timeout
    for (int i = 0; i < 6; i++) begin
      check("t5_ready_held", {30'b0, req_ready}, 32'h0);
      check("t5_no_start", {31'b0, eng_start}, 32'h0);
      @(negedge clk);
      #1;
    end
    busy_force = 1'b0;
    #1;
    check("t5_ready_release", {30'b0, req_ready}, 32'h1);
    tx_q.push_back(8'h77);
    rsp_q.push_back({2'b01, 8'h88});
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(negedge clk);
    #1;
    check("t5_start", {31'b0, eng_start}, 32'h1);
    wait_quiet();
    check("t5_no_abort", {30'b0, abort_seen}, 32'h0);

    // 6: reset while the engine transfer is in flight
    clear_marks();
    eng_lat = 10;
    sc = start_count;
    send_byte(0, 8'h81, 1'b0);
    t = 0;
    while (start_count == sc && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_cs", {31'b0, cs}, 32'h1);
    check("t6_grant", {30'b0, grant}, 32'h0);
    check("t6_ready", {30'b0, req_ready}, 32'h0);
    check("t6_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("t6_abort", {30'b0, abort}, 32'h0);
    check("t6_eng_start", {31'b0, eng_start}, 32'h0);
    check("t6_tx_data", {24'b0, eng_tx_data}, 32'h0);
    check("t6_rsp_data", {24'b0, rsp_data}, 32'h0);
    tx_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rc = rsp_count;
    dc = done_count;
    t = 0;
    while (done_count == dc && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("t6_late_done", done_count - dc, 1);
    repeat (3) @(negedge clk);
    #1;
    check("t6_no_rsp", rsp_count - rc, 0);
    check("t6_idle_grant", {30'b0, grant}, 32'h0);
    check("t6_idle_cs", {31'b0, cs}, 32'h1);
    eng_lat = 3;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
